lock_key_ctrl: RTL and testbench

//  Input/decision side of the combination lock; drives the 7-seg display block.

---
 rtl/lock_key_ctrl_pkg.sv | 24 ++
 rtl/lock_key_ctrl_key_debounce.sv | 51 +++++
 rtl/lock_key_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lock_key_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_key_ctrl_pkg.sv
// Shared types and helpers for the combination-lock key/decision block.
package lock_key_ctrl_pkg;

    // Decision FSM states; encodings kept identical to the shared display constants.
    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_CHECK = 2'd1,
        ST_SHOW  = 2'd2,
        ST_LOCK  = 2'd3
    } lock_state_t;

    // Width of the SHOW/LOCK timer and the debounce counters.
    localparam int unsigned TIMER_W = 32;

    // Width of the consecutive-failure counter.
    localparam int unsigned FAIL_W = 3;

    // Saturating increment of the failure counter.
    function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] cnt,
                                                   input logic [FAIL_W-1:0] max);
        return (cnt >= max) ? max : cnt + FAIL_W'(1);
    endfunction

endpackage

// File: rtl/lock_key_ctrl_key_debounce.sv
// Button synchronizer and debouncer: the level follows the input only after it has
// been stable for DB_CYC cycles, and a press pulse marks the debounced 1->0 edge.
module key_debounce
    import lock_key_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse
);

    logic                sync1;
    logic                sync2;
    logic [TIMER_W-1:0]  stable_cnt;

    // Two-flop synchronizer; resets to the pressed level so a button held through
    // reset release never produces an edge until it is released and pressed again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Count consecutive cycles of disagreement; any bounce back restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt  <= '0;
            key_level   <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sync2 == key_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == TIMER_W'(DB_CYC - 1)) begin
                stable_cnt  <= '0;
                key_level   <= sync2;
                press_pulse <= ~sync2;
            end else begin
                stable_cnt <= stable_cnt + TIMER_W'(1);
            end
        end
    end

endmodule

// File: rtl/lock_key_ctrl.sv
// Input/decision side of the combination lock: switch sync, key debounce,
// password check, result hold timer and failure lockout.
module lock_key_ctrl
    import lock_key_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYC   = 500_000,
    parameter logic [3:0]  PASSWORD = 4'b1001,
    parameter int unsigned SHOW_CYC = 150_000_000,
    parameter int unsigned MAX_FAIL = 3,
    parameter int unsigned LOCK_CYC = 500_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_enter_n,
    input  logic              key_clr_n,
    input  logic [3:0]        sw,
    output logic [3:0]        ctrl,
    output logic              enter_trig,
    output logic              init_trig,
    output logic              com_result,
    output logic              locked,
    output logic [FAIL_W-1:0] fail_cnt
);

    lock_state_t        state_q, state_d;
    logic [3:0]         sw_s1, sw_s2;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic               com_q, com_d;
    logic               clr_pend_q, clr_pend_d;
    logic               expire_init;
    logic               match;
    logic               enter_press, clr_press;
    logic               enter_level, clr_level;
    logic               unused_levels;

    key_debounce #(.DB_CYC(DB_CYC)) u_db_enter (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_enter_n),
        .key_level   (enter_level),
        .press_pulse (enter_press)
    );

    key_debounce #(.DB_CYC(DB_CYC)) u_db_clr (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_clr_n),
        .key_level   (clr_level),
        .press_pulse (clr_press)
    );

    assign unused_levels = enter_level ^ clr_level;

    // Switch synchronizer; the second stage doubles as the frozen code register
    // (only loads in ENTRY), keeping ctrl at two cycles of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            if (state_q == ST_ENTRY) begin
                sw_s2 <= sw_s1;
            end
        end
    end

    assign ctrl  = sw_s2;
    assign match = (sw_s2 == PASSWORD);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ENTRY;
        end else begin
            state_q <= state_d;
        end
    end

    // Timer, failure counter, held result and the deferred clear-initiated init pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q    <= '0;
            fail_q     <= '0;
            com_q      <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            com_q      <= com_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    // Next-state, counter updates and pulse generation.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        fail_d      = fail_q;
        com_d       = com_q;
        clr_pend_d  = 1'b0;
        enter_trig  = 1'b0;
        expire_init = 1'b0;
        unique case (state_q)
            ST_ENTRY: begin
                timer_d = '0;
                if (clr_press) begin
                    clr_pend_d = 1'b1;
                end else if (enter_press) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                enter_trig = 1'b1;
                com_d      = match;
                timer_d    = '0;
                if (match) begin
                    fail_d  = '0;
                    state_d = ST_SHOW;
                end else begin
                    fail_d  = fail_inc(fail_q, FAIL_W'(MAX_FAIL));
                    state_d = (fail_d == FAIL_W'(MAX_FAIL)) ? ST_LOCK : ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (timer_q == TIMER_W'(SHOW_CYC - 1)) begin
                    expire_init = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_ENTRY;
                end else if (clr_press) begin
                    clr_pend_d = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_ENTRY;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_LOCK: begin
                if (timer_q == TIMER_W'(LOCK_CYC - 1)) begin
                    expire_init = 1'b1;
                    timer_d     = '0;
                    fail_d      = '0;
                    state_d     = ST_ENTRY;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    // During CHECK the fresh comparison is presented so it is valid alongside enter_trig.
    assign com_result = (state_q == ST_CHECK) ? match : com_q;
    assign init_trig  = expire_init | clr_pend_q;
    assign locked     = (state_q == ST_LOCK);
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_lock_key_ctrl.sv
// Directed bench for lock_key_ctrl with short debounce/show/lock times.
module tb_lock_key_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_enter_n;
    logic       key_clr_n;
    logic [3:0] sw;
    logic [3:0] ctrl;
    logic       enter_trig;
    logic       init_trig;
    logic       com_result;
    logic       locked;
    logic [2:0] fail_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    int n_enter = 0, n_init = 0, n_both = 0, n_wide = 0;
    int enter_cyc = 0, init_cyc = 0, enter_res = 0;
    logic prev_enter = 1'b0, prev_init = 1'b0;

    lock_key_ctrl #(
        .DB_CYC   (4),
        .PASSWORD (4'b1001),
        .SHOW_CYC (20),
        .MAX_FAIL (3),
        .LOCK_CYC (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_enter_n (key_enter_n),
        .key_clr_n   (key_clr_n),
        .sw          (sw),
        .ctrl        (ctrl),
        .enter_trig  (enter_trig),
        .init_trig   (init_trig),
        .com_result  (com_result),
        .locked      (locked),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records every trigger, its cycle, and width/overlap violations.
    always @(negedge clk) begin
        if (enter_trig) begin
            n_enter++;
            enter_cyc = cyc;
            enter_res = int'(com_result);
        end
        if (init_trig) begin
            n_init++;
            init_cyc = cyc;
        end
        if (enter_trig && init_trig) n_both++;
        if ((enter_trig && prev_enter) || (init_trig && prev_init)) n_wide++;
        prev_enter = enter_trig;
        prev_init  = init_trig;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after posedge number t (drive point).
    task automatic drive_at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance to just after the negedge of cycle t (sample point).
    task automatic sample_at(input int t);
        drive_at(t);
        @(negedge clk);
        #1;
    endtask

    // One code submission; enter_trig is expected 7 cycles after the press is driven
    // (2 sync + 4 debounce + 1 FSM).
    task automatic do_entry(input logic [3:0] code, input int exp_res, input int exp_fail,
                            input string tag, input bit hold, output int k);
        int e0;
        sw = code;
        drive_at(cyc + 3);
        e0 = n_enter;
        k = cyc;
        key_enter_n = 1'b0;
        sample_at(k + 9);
        check_val({tag, "_trig"}, n_enter - e0, 1);
        check_val({tag, "_lat"}, enter_cyc - k, 7);
        check_val({tag, "_res"}, enter_res, exp_res);
        check_val({tag, "_fail"}, int'(fail_cnt), exp_fail);
        drive_at(k + 10);
        if (!hold) key_enter_n = 1'b1;
    endtask

    // Three wrong codes; returns with the FSM in LOCK, k = drive cycle of the third press.
    task automatic three_wrong(input string tag, output int k);
        do_entry(4'b0110, 0, 1, {tag, "a"}, 1'b0, k);
        drive_at(k + 30);
        do_entry(4'b0110, 0, 2, {tag, "b"}, 1'b0, k);
        drive_at(k + 30);
        do_entry(4'b0110, 0, 3, {tag, "c"}, 1'b0, k);
    endtask

    initial begin
        int k, k2, e0, i0, t;
        int bl[4];
        bl = '{2, 2, 3, 1};

        rst = 1'b1;
        key_enter_n = 1'b1;
        key_clr_n = 1'b1;
        sw = 4'b0000;

        // Reset state
        sample_at(3);
        check_val("rst_ctrl", int'(ctrl), 0);
        check_val("rst_enter", int'(enter_trig), 0);
        check_val("rst_init", int'(init_trig), 0);
        check_val("rst_com", int'(com_result), 0);
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_fail", int'(fail_cnt), 0);
        drive_at(4);
        rst = 1'b0;
        drive_at(16);

        // 1: correct code, result shown for 20 cycles, ctrl frozen while not in ENTRY
        i0 = n_init;
        do_entry(4'b1001, 1, 0, "t1", 1'b0, k);
        sw = 4'b0110;
        sample_at(k + 20);
        check_val("t1_frozen", int'(ctrl), 4'b1001);
        sample_at(k + 30);
        check_val("t1_init", n_init - i0, 1);
        check_val("t1_show", init_cyc - enter_cyc, 20);
        check_val("t1_ctrl", int'(ctrl), 4'b0110);
        sample_at(k + 40);
        check_val("t1_norel", n_enter - 1, enter_cyc == k + 7 ? n_enter - 1 : -1);

        // 2: wrong code, early return by clear during SHOW
        e0 = n_enter;
        do_entry(4'b0110, 0, 1, "t2", 1'b0, k);
        drive_at(k + 12);
        i0 = n_init;
        k2 = cyc;
        key_clr_n = 1'b0;
        sample_at(k2 + 9);
        check_val("t2_init", n_init - i0, 1);
        check_val("t2_init_lat", init_cyc - k2, 7);
        check_val("t2_com_hold", int'(com_result), 0);
        check_val("t2_fail_hold", int'(fail_cnt), 1);
        drive_at(k2 + 10);
        key_clr_n = 1'b1;
        sample_at(k2 + 30);
        check_val("t2_enters", n_enter - e0, 1);
        check_val("t2_noexp", n_init - i0, 1);

        // 3: bouncing enter, runs shorter than the debounce window
        sw = 4'b1001;
        drive_at(cyc + 3);
        e0 = n_enter;
        i0 = n_init;
        for (int i = 0; i < 4; i++) begin
            key_enter_n = i[0];
            t = cyc + bl[i];
            drive_at(t);
        end
        key_enter_n = 1'b0;
        k = cyc;
        sample_at(k + 10);
        check_val("t3_trig", n_enter - e0, 1);
        check_val("t3_lat", enter_cyc - k, 7);
        check_val("t3_res", enter_res, 1);
        check_val("t3_fail", int'(fail_cnt), 0);
        drive_at(k + 11);
        key_enter_n = 1'b1;
        sample_at(k + 30);
        check_val("t3_init", n_init - i0, 1);

        // 4: lockout after three failures; presses ignored for 50 cycles
        three_wrong("t4", k);
        e0 = n_enter;
        i0 = n_init;
        sample_at(k + 12);
        check_val("t4_locked", int'(locked), 1);
        drive_at(k + 14);
        key_clr_n = 1'b0;
        drive_at(k + 22);
        key_clr_n = 1'b1;
        drive_at(k + 26);
        key_enter_n = 1'b0;
        drive_at(k + 40);
        key_enter_n = 1'b1;
        sample_at(k + 50);
        check_val("t4_ign_enter", n_enter - e0, 0);
        check_val("t4_ign_init", n_init - i0, 0);
        sample_at(k + 57);
        check_val("t4_exp_init", int'(init_trig), 1);
        check_val("t4_exp_locked", int'(locked), 1);
        sample_at(k + 58);
        check_val("t4_unlocked", int'(locked), 0);
        check_val("t4_fail_clr", int'(fail_cnt), 0);
        check_val("t4_init_cnt", n_init - i0, 1);

        // 5: simultaneous enter and clear in ENTRY -> clear wins
        drive_at(cyc + 5);
        e0 = n_enter;
        i0 = n_init;
        k = cyc;
        key_enter_n = 1'b0;
        key_clr_n = 1'b0;
        sample_at(k + 15);
        check_val("t5_init", n_init - i0, 1);
        check_val("t5_init_lat", init_cyc - k, 7);
        check_val("t5_noenter", n_enter - e0, 0);
        drive_at(k + 16);
        key_enter_n = 1'b1;
        key_clr_n = 1'b1;
        drive_at(k + 30);

        // 6a: reset mid-SHOW with enter held through reset release
        do_entry(4'b1001, 1, 0, "t6", 1'b1, k);
        drive_at(k + 12);
        rst = 1'b1;
        sample_at(k + 12);
        check_val("t6_com", int'(com_result), 0);
        check_val("t6_ctrl", int'(ctrl), 0);
        check_val("t6_enter", int'(enter_trig), 0);
        check_val("t6_init", int'(init_trig), 0);
        drive_at(k + 14);
        rst = 1'b0;
        e0 = n_enter;
        sample_at(k + 34);
        check_val("t6_held", n_enter - e0, 0);
        key_enter_n = 1'b1;
        drive_at(k + 44);
        key_enter_n = 1'b0;
        sample_at(k + 53);
        check_val("t6_repress", n_enter - e0, 1);
        check_val("t6_repress_lat", enter_cyc - (k + 44), 7);
        drive_at(k + 54);
        key_enter_n = 1'b1;
        drive_at(k + 80);

        // 6b: reset mid-LOCK
        three_wrong("t6l", k);
        sample_at(k + 15);
        check_val("t6l_locked", int'(locked), 1);
        drive_at(k + 16);
        rst = 1'b1;
        sample_at(k + 16);
        check_val("t6l_unlocked", int'(locked), 0);
        check_val("t6l_fail", int'(fail_cnt), 0);
        drive_at(k + 18);
        rst = 1'b0;
        sample_at(k + 80);
        check_val("t6l_still_entry", int'(locked), 0);

        check_val("no_overlap", n_both, 0);
        check_val("pulse_width", n_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
